// File: rtl/image_preload_loader.sv
// image_preload_loader
// Host-side driver for the image buffer preload port. Takes one raster-order
// frame of IMG_SIZE*IMG_SIZE pixels per start command and turns it into
// registered write beats. preload_done is raised only for a correctly framed
// image; a bad frame is parked in ERR with a sticky frame_err.
module image_preload_loader #(
    parameter  int IMG_SIZE   = 5,
    parameter  int DATA_WIDTH = 8,
    localparam int N          = IMG_SIZE * IMG_SIZE,
    localparam int AW         = $clog2(N),
    localparam int CW         = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  preload_en,
    output logic [AW-1:0]         preload_addr,
    output logic [DATA_WIDTH-1:0] preload_pixel,
    output logic                  preload_done,
    output logic                  busy,
    output logic                  frame_err,
    output logic [CW-1:0]         pixel_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]         counter;
    logic                  vld_p0;
    logic [AW-1:0]         addr_p0;
    logic [DATA_WIDTH-1:0] pixel_p0;
    logic                  done_flag;
    logic                  err_flag;

    logic in_load;
    logic accept;
    logic restart;
    logic is_final;

    // Handshake is decoded from the state register alone so s_ready never
    // depends on s_valid.
    assign in_load  = (state == LOAD);
    assign accept   = s_valid && in_load;
    assign restart  = start && !in_load;
    assign is_final = (counter == CW'(N - 1));

    // State register; rst and clear both return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: a beat carrying s_last or landing on the last slot
    // closes the frame, which is good only when both coincide.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && (s_last || is_final)) begin
                    state_next = (s_last && is_final) ? DONE : ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: register each accepted beat as a one-cycle write, and track
    // the frame counter plus the done/error status flags.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            counter   <= '0;
            vld_p0    <= 1'b0;
            addr_p0   <= '0;
            pixel_p0  <= '0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            vld_p0 <= accept;
            if (accept) begin
                addr_p0  <= counter[AW-1:0];
                pixel_p0 <= s_data;
                if (counter < CW'(N)) begin
                    counter <= counter + 1'b1;
                end
            end
            if (restart) begin
                counter   <= '0;
                done_flag <= 1'b0;
                err_flag  <= 1'b0;
            end else begin
                // done follows the DONE state by one cycle so the final
                // write has landed before anyone reads on preload_done
                if (state == DONE) begin
                    done_flag <= 1'b1;
                end
                if (in_load && state_next == ERR) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

    assign s_ready       = in_load;
    assign busy          = in_load;
    assign preload_en    = vld_p0;
    assign preload_addr  = addr_p0;
    assign preload_pixel = pixel_p0;
    assign preload_done  = done_flag;
    assign frame_err     = err_flag;
    assign pixel_count   = counter;

endmodule

// File: tb/tb_image_preload_loader.sv
// Testbench for image_preload_loader: table of frame scenarios plus
// hand-written clear/reload sequences, with a write scoreboard.
module tb_image_preload_loader;

    localparam int IMG_SIZE   = 5;
    localparam int DATA_WIDTH = 8;
    localparam int N          = IMG_SIZE * IMG_SIZE;
    localparam int AW         = $clog2(N);
    localparam int CW         = $clog2(N + 1);

    logic                  clk;
    logic                  rst;
    logic                  clear;
    logic                  start;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  preload_en;
    logic [AW-1:0]         preload_addr;
    logic [DATA_WIDTH-1:0] preload_pixel;
    logic                  preload_done;
    logic                  busy;
    logic                  frame_err;
    logic [CW-1:0]         pixel_count;

    image_preload_loader #(
        .IMG_SIZE  (IMG_SIZE),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .preload_en   (preload_en),
        .preload_addr (preload_addr),
        .preload_pixel(preload_pixel),
        .preload_done (preload_done),
        .busy         (busy),
        .frame_err    (frame_err),
        .pixel_count  (pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } beat_t;

    typedef struct {
        int n_beats;
        int last_at;
        bit bubble;
        bit exp_done;
        bit exp_err;
        int exp_count;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[4];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int beat_idx = 0;
    bit exp_done = 1'b0;
    bit chk_done_nxt = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard monitor: sample away from the active edge. Writes seen now
    // are popped and compared; handshakes visible now are pushed as the
    // writes expected one cycle after the coming edge.
    always @(negedge clk) begin
        beat_t b;
        if (chk_done_nxt) begin
            chk("done_after_last_write", preload_done, exp_done);
            chk_done_nxt = 1'b0;
        end
        if (preload_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                b = sb.pop_front();
                chk("wr_addr", preload_addr, b.addr);
                chk("wr_pixel", preload_pixel, b.data);
            end
            if (int'(preload_addr) == N - 1) begin
                chk("done_low_during_last_write", preload_done, 0);
                chk_done_nxt = 1'b1;
            end
        end
        if (rst || clear || (start && !busy)) begin
            beat_idx = 0;
        end else if (s_valid && s_ready) begin
            sb.push_back('{addr: beat_idx, data: int'(s_data)});
            beat_idx++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start, then confirm LOAD was entered with status cleared.
    task automatic start_frame();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_clears_done", preload_done, 0);
        chk("start_clears_err", frame_err, 0);
        chk("start_ready", s_ready, 1);
        chk("start_count_zero", pixel_count, 0);
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send_beat(input int d, input bit last, input bit st);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = DATA_WIDTH'(d);
        s_last  = last;
        start   = st;
        @(negedge clk);
        while (!s_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) chk("beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_done = v.exp_done;
        wr_cnt   = 0;
        start_frame();
        for (int i = 0; i < v.n_beats; i++) begin
            send_beat(i + 10, (i + 1 == v.last_at), v.bubble && (i == 12));
            if (v.bubble && (i % 2 == 0)) idle(2);
        end
        idle(3);
        @(negedge clk);
        chk($sformatf("v%0d_done", idx), preload_done, v.exp_done);
        chk($sformatf("v%0d_err", idx), frame_err, v.exp_err);
        chk($sformatf("v%0d_count", idx), pixel_count, v.exp_count);
        chk($sformatf("v%0d_ready_after", idx), s_ready, 0);
        chk($sformatf("v%0d_busy_after", idx), busy, 0);
        chk($sformatf("v%0d_writes", idx), wr_cnt, v.exp_count);
        chk($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // n_beats, last_at, bubble, exp_done, exp_err, exp_count
        tbl[0] = '{n_beats: 25, last_at: 25, bubble: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_count: 25};
        tbl[1] = '{n_beats: 25, last_at: 25, bubble: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_count: 25};
        tbl[2] = '{n_beats: 11, last_at: 11, bubble: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_count: 11};
        tbl[3] = '{n_beats: 25, last_at: 0,  bubble: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_count: 25};

        rst     = 1'b1;
        clear   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", preload_en, 0);
        chk("rst_addr", preload_addr, 0);
        chk("rst_pixel", preload_pixel, 0);
        chk("rst_done", preload_done, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_count", pixel_count, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) run_vec(tbl[k], k);

        // Clear on the edge after beat 7 is accepted (from ERR via start).
        exp_done = 1'b0;
        wr_cnt   = 0;
        start_frame();
        for (int i = 0; i < 7; i++) send_beat(i + 10, 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_en_killed", preload_en, 0);
        chk("clr_count", pixel_count, 0);
        chk("clr_busy", busy, 0);
        chk("clr_ready", s_ready, 0);
        chk("clr_writes", wr_cnt, 7);
        chk("clr_sb_empty", sb.size(), 0);
        idle(3);
        chk("clr_no_more_writes", wr_cnt, 7);

        // Full frame from IDLE after clear, then reload straight from DONE.
        run_vec(tbl[0], 4);
        run_vec(tbl[0], 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/image_preload_loader.md
Name: image_preload_loader

Overview:
- Host-side driver of the image buffer preload interface.
- Accepts a valid/ready pixel stream in raster order, one frame of IMG_SIZE*IMG_SIZE pixels per start command.
- Generates preload_en, preload_addr and preload_pixel write beats, then asserts preload_done once the whole frame is written.
- Checks frame length against s_last and flags framing errors. A bad frame never releases preload_done.

Parameters:
IMG_SIZE, 5, image edge length in pixels; frame length N = IMG_SIZE*IMG_SIZE
DATA_WIDTH, 8, pixel width in bits

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
clear  input  1  synchronous soft reset, same effect as rst
start  input  1  single-cycle pulse that begins loading a frame
s_valid  input  1  stream pixel valid
s_ready  output  1  stream pixel ready
s_data  input  DATA_WIDTH  stream pixel value
s_last  input  1  marks final pixel of the frame
preload_en  output  1  one-cycle write strobe to the image buffer
preload_addr  output  $clog2(N)  write address
preload_pixel  output  DATA_WIDTH  write data
preload_done  output  1  frame fully written; level, held until next start, clear or rst
busy  output  1  high while in LOAD
frame_err  output  1  sticky framing error
pixel_count  output  $clog2(N+1)  number of beats accepted this frame

Behaviour:
- States: IDLE, LOAD, DONE, ERR. The state is held in a register.
- rst/clear: state goes to IDLE. Counter, preload_en, preload_addr, preload_pixel, preload_done and frame_err all go to 0. rst and clear take priority over all other inputs.
- s_ready = (state==LOAD). It is decoded combinationally from the state register only, never from s_valid.
- busy = (state==LOAD).
- start in IDLE, DONE or ERR:
  - Next state is LOAD.
  - Counter, preload_done and frame_err clear on the same edge.
  - preload_done therefore drops the cycle after start.
- start in LOAD: ignored.
- Beat accepted at edge E when s_valid && s_ready:
  - preload_en=1, preload_addr=counter and preload_pixel=s_data are registered at E. They are visible for exactly the one cycle after E.
  - The counter increments at E.
  - Latency is 1 cycle, with no combinational path from s_data to preload_pixel.
- preload_en is 0 in every cycle that follows an edge with no accepted beat. Stream bubbles therefore produce no write pulses.
- Final beat, counter==N-1, s_last=1: state goes to DONE at E.
  - preload_done is set at E+1, one cycle after the last preload_en pulse.
  - The buffer has completed the final write before any read can be gated by preload_done.
- Early s_last (counter<N-1):
  - The beat is still written to the buffer.
  - State goes to ERR and frame_err=1 at E.
  - preload_done stays 0.
- Missing s_last (counter==N-1, s_last=0):
  - The beat is written.
  - State goes to ERR and frame_err=1.
  - preload_done stays 0.
- DONE and ERR: s_ready=0, so no further beats are accepted. The block holds until start, clear or rst.
- pixel_count equals the counter, which saturates at N and never wraps.
- preload_addr ranges 0..N-1 and never exceeds N-1.
- Reset or clear mid-frame: any pending preload_en pulse is killed on that edge. The next start reloads from address 0.
- A start and a handshake on the same edge can only coincide in LOAD, where start is ignored and the beat is processed normally.

Test Plan:
- Full frame: start, then 25 back-to-back beats with s_data=addr+10 and s_last on beat 25 -> 25 preload_en pulses, addr 0..24, data 10..34. preload_done rises one cycle after the addr-24 pulse. s_ready=0 afterward, pixel_count=25, frame_err=0.
- Bubbles: same frame with s_valid toggling 1,0,0,1 and start ignored mid-load -> exactly 25 pulses with contiguous addresses and no duplicate writes. Result is identical to the full-frame case.
- Early last: s_last on beat 11 -> 11 writes (addr 0..10), state ERR, frame_err=1, pixel_count=11, preload_done=0, s_ready=0.
- Missing last: 25 beats with s_last=0 throughout -> 25 writes, frame_err=1, preload_done=0. A following start clears frame_err and re-enters LOAD.
- Clear mid-frame: clear on the edge after beat 7 is accepted -> no further preload_en pulses, pixel_count=0, IDLE. A new start plus a full frame writes from addr 0.
- Reload: start while in DONE -> preload_done=0 the next cycle, s_ready=1, and a second full frame completes with preload_done again.
